// File: rtl/spi_lmx_axil_regs.sv
// spi_lmx_axil_regs: AXI4-Lite register map driving an LMX 24-bit SPI master
module spi_lmx_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FRAME_BITS         = 24,
    parameter int CSB_GAP            = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            spi_sclk,
    output logic                            spi_mosi,
    output logic                            spi_csb,
    input  logic                            spi_miso
);
    localparam int NW = $clog2(FRAME_BITS);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;
    state_t                  r_state;
    logic                    r_awready, r_bvalid, r_arready, r_rvalid;
    logic [31:0]             r_rdata;
    logic [FRAME_BITS-1:0]   r_tx, r_sh;
    logic [7:0]              r_clkdiv, r_div, r_h;
    logic [NW-1:0]           r_n;
    logic [15:0]             r_samp, r_rx;
    logic                    r_ovr, r_done, r_start, r_busy;
    logic                    r_miso_q1, r_miso_q2, r_sclk, r_mosi, r_csb;
    logic                    w_wr, w_rd, w_busy, w_tx_wr, w_clr, w_done_set, w_hdone;
    logic [1:0]              w_wsel;
    logic [31:0]             w_status, w_rmux;
    logic                    w_unused;
    assign w_wr       = r_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign w_rd       = r_arready & s00_axi_arvalid;
    assign w_wsel     = s00_axi_awaddr[3:2];
    assign w_busy     = r_busy | r_start;
    assign w_tx_wr    = w_wr && w_wsel == 2'd0;
    assign w_clr      = w_wr && w_wsel == 2'd2 && s00_axi_wstrb[0];
    assign w_done_set = r_state == S_GAP && r_h == 8'(CSB_GAP - 1);
    assign w_hdone    = r_h == r_div;
    assign w_status   = {29'd0, r_done, r_ovr, w_busy};
    assign w_unused   = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                          s00_axi_araddr[1:0], s00_axi_wdata[31:24], s00_axi_wstrb[3]};
    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_csb  = r_csb;
    // Read mux, sampled into rdata on the address handshake so STATUS returns its pre-update value
    always_comb begin
        w_rmux = s00_axi_araddr[3:2] == 2'd0 ? 32'(r_tx) :
                 s00_axi_araddr[3:2] == 2'd1 ? {24'd0, r_clkdiv} :
                 s00_axi_araddr[3:2] == 2'd2 ? w_status : {16'd0, r_rx};
    end
    // AXI handshakes: one-cycle ready pulses, valid held until the master accepts
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= !r_awready && s00_axi_awvalid && s00_axi_wvalid && !r_bvalid;
            r_bvalid  <= w_wr ? 1'b1 : (s00_axi_bready ? 1'b0 : r_bvalid);
            r_arready <= !r_arready && s00_axi_arvalid && !r_rvalid;
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rmux;
            end else if (s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end
    // Register file: frame latch and start request, CLKDIV, sticky flags with set-over-clear priority
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_tx     <= '0;
            r_clkdiv <= '0;
            r_start  <= 1'b0;
            r_ovr    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_start <= w_tx_wr && !w_busy;
            if (w_tx_wr && !w_busy)
                for (int b = 0; b < FRAME_BITS / 8; b++)
                    if (s00_axi_wstrb[b]) r_tx[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            if (w_wr && w_wsel == 2'd1 && s00_axi_wstrb[0]) r_clkdiv <= s00_axi_wdata[7:0];
            r_ovr  <= (w_tx_wr && w_busy) || (r_ovr && !(w_clr && s00_axi_wdata[1]));
            r_done <= w_done_set || (r_done && !(w_clr && s00_axi_wdata[2]));
        end
    end
    // Two-flop synchronizer for the asynchronous MUXout readback
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) {r_miso_q2, r_miso_q1} <= 2'b00;
        else                  {r_miso_q2, r_miso_q1} <= {r_miso_q1, spi_miso};
    end
    // SPI engine: mode-0 shift out MSB first, sample at the end of each high half-period
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_n     <= '0;
            r_div   <= '0;
            r_sh    <= '0;
            r_samp  <= '0;
            r_rx    <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_csb   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (r_start) begin
                    r_state <= S_SETUP;
                    r_csb   <= 1'b0;
                    r_mosi  <= r_tx[FRAME_BITS-1];
                    r_sh    <= r_tx;
                    r_n     <= NW'(FRAME_BITS - 1);
                    r_div   <= r_clkdiv;
                    r_h     <= '0;
                    r_busy  <= 1'b1;
                end
                S_SETUP: if (w_hdone) begin
                    r_state <= S_HIGH;
                    r_sclk  <= 1'b1;
                    r_h     <= '0;
                end else r_h <= r_h + 8'd1;
                S_HIGH: if (w_hdone) begin
                    r_state <= S_LOW;
                    r_sclk  <= 1'b0;
                    r_h     <= '0;
                    r_samp  <= {r_samp[14:0], r_miso_q2};
                    if (r_n != '0) begin
                        r_sh   <= r_sh << 1;
                        r_mosi <= r_sh[FRAME_BITS-2];
                    end
                end else r_h <= r_h + 8'd1;
                S_LOW: if (w_hdone) begin
                    r_h <= '0;
                    if (r_n != '0) begin
                        r_n     <= r_n - 1'b1;
                        r_sclk  <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_csb   <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_GAP;
                    end
                end else r_h <= r_h + 8'd1;
                S_GAP: if (w_done_set) begin
                    r_state <= S_IDLE;
                    r_rx    <= r_samp;
                    r_busy  <= 1'b0;
                    r_h     <= '0;
                end else r_h <= r_h + 8'd1;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_lmx_axil_regs.sv
// tb_spi_lmx_axil_regs: directed vector bench for the AXI-Lite LMX SPI block
module tb_spi_lmx_axil_regs;
    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        sclk, mosi, csb, miso;
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_csb_lo, m_hi, m_rise;
    logic [23:0] m_cap;
    logic        m_prev, m_clr;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [16];

    spi_lmx_axil_regs dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .spi_sclk(sclk), .spi_mosi(mosi), .spi_csb(csb),
        .spi_miso(miso)
    );

    always #5 clk = ~clk;

    // SPI pin monitor: csb-low cycles, sclk-high cycles, rising edges and the bits seen on them
    always @(negedge clk) begin
        if (m_clr) begin
            m_csb_lo = 0; m_hi = 0; m_rise = 0; m_cap = '0; m_prev = 1'b0;
        end else begin
            if (!csb) m_csb_lo++;
            if (sclk) m_hi++;
            if (sclk && !m_prev) begin m_rise++; m_cap = {m_cap[22:0], mosi}; end
            m_prev = sclk;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++; n_err++;
        $display("FAIL %s: timeout got 0 expected 1", nm);
    endtask

    task automatic mon_clear();
        m_clr = 1'b1;
        @(negedge clk);
        #1 m_clr = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo("awready");
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo("bvalid");
        chk("bresp", 32'(bresp), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int k;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo("arready");
        @(posedge clk); #1 arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo("rvalid");
        d = rdata;
        chk("rresp", 32'(rresp), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int maxp, output logic [31:0] s);
        int k;
        k = 0; s = 32'h1;
        while (s[0] && k < maxp) begin axi_read(4'h8, s); k++; end
        if (s[0]) tmo("frame_end");
    endtask

    initial begin
        logic [31:0] d;
        int cnt;
        aresetn = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
        miso = 1'b0; m_clr = 1'b1;
        tbl[0]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0};
        tbl[1]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0};
        tbl[2]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0};
        tbl[3]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0};
        tbl[4]  = '{1'b1, 4'h4, 32'h0000_015A, 4'hF, 32'h0};
        tbl[5]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h5A};
        tbl[6]  = '{1'b1, 4'h4, 32'h0000_0033, 4'h0, 32'h0};
        tbl[7]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h5A};
        tbl[8]  = '{1'b1, 4'h4, 32'hFFFF_FF00, 4'hE, 32'h0};
        tbl[9]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h5A};
        tbl[10] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0};
        tbl[12] = '{1'b1, 4'h8, 32'h0000_0006, 4'hF, 32'h0};
        tbl[13] = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0};
        tbl[14] = '{1'b1, 4'h4, 32'h0,         4'h1, 32'h0};
        tbl[15] = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0};
        repeat (3) @(negedge clk);
        chk("rst_csb", 32'(csb), 32'h1);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_bvalid", 32'(bvalid), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        aresetn = 1'b1;
        m_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            else begin
                axi_read(tbl[i].addr, d);
                chk($sformatf("vec%0d", i), d, tbl[i].exp);
            end
        end
        // frame at CLKDIV=0, miso low
        mon_clear();
        axi_write(4'h0, 32'h0000_A5C3, 4'hF);
        wait_idle(200, d);
        chk("f1_status", d, 32'h4);
        chk("f1_rises", 32'(m_rise), 32'd24);
        chk("f1_mosi", 32'(m_cap), 32'h0000_A5C3);
        chk("f1_csb_lo", 32'(m_csb_lo), 32'd49);
        axi_read(4'hC, d);
        chk("f1_rx", d, 32'h0);
        // miso high readback
        axi_write(4'h8, 32'h4, 4'hF);
        axi_read(4'h8, d);
        chk("done_clr", d, 32'h0);
        miso = 1'b1;
        mon_clear();
        axi_write(4'h0, 32'h0080_0000, 4'hF);
        wait_idle(200, d);
        chk("f2_status", d, 32'h4);
        chk("f2_mosi", 32'(m_cap), 32'h80_0000);
        axi_read(4'hC, d);
        chk("f2_rx", d, 32'hFFFF);
        // CLKDIV=3 with an overrun write
        miso = 1'b0;
        axi_write(4'h4, 32'h3, 4'hF);
        mon_clear();
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h0, 32'h2, 4'hF);
        wait_idle(400, d);
        chk("f3_status", d, 32'h6);
        chk("f3_mosi", 32'(m_cap), 32'h1);
        chk("f3_rises", 32'(m_rise), 32'd24);
        chk("f3_sclk_hi", 32'(m_hi), 32'd96);
        chk("f3_csb_lo", 32'(m_csb_lo), 32'd196);
        axi_read(4'h0, d);
        chk("f3_tx", d, 32'h1);
        axi_write(4'h8, 32'h6, 4'hF);
        axi_read(4'h8, d);
        chk("f3_clr", d, 32'h0);
        // write response back-pressure
        bready = 1'b0;
        @(negedge clk);
        awaddr = 4'h4; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
        if (cnt >= 50) tmo("bp_aw1");
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (bvalid) cnt++; end
        chk("bp_bvalid_hold", 32'(cnt), 32'd10);
        awaddr = 4'h4; wdata = 32'h9; awvalid = 1'b1; wvalid = 1'b1;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (awready) cnt++; end
        chk("bp_aw_stall", 32'(cnt), 32'd0);
        axi_read(4'h4, d);
        chk("bp_div1", d, 32'h7);
        bready = 1'b1;
        cnt = 0;
        while (!awready && cnt < 50) begin @(negedge clk); cnt++; end
        if (cnt >= 50) tmo("bp_aw2");
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_bvalid_clr", 32'(bvalid), 32'h0);
        axi_read(4'h4, d);
        chk("bp_div2", d, 32'h9);
        // asynchronous reset mid-frame
        axi_write(4'h4, 32'h3, 4'hF);
        axi_write(4'h0, 32'hFF_FFFF, 4'hF);
        repeat (30) @(negedge clk);
        chk("mid_csb", 32'(csb), 32'h0);
        #2 aresetn = 1'b0;
        #1;
        chk("async_csb", 32'(csb), 32'h1);
        chk("async_sclk", 32'(sclk), 32'h0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        axi_read(4'h8, d);
        chk("post_rst_status", d, 32'h0);
        axi_read(4'h4, d);
        chk("post_rst_div", d, 32'h0);
        mon_clear();
        axi_write(4'h0, 32'h12_3456, 4'hF);
        wait_idle(200, d);
        chk("f4_status", d, 32'h4);
        chk("f4_mosi", 32'(m_cap), 32'h12_3456);
        chk("f4_rises", 32'(m_rise), 32'd24);
        // widest half-period
        axi_write(4'h4, 32'hFF, 4'hF);
        axi_read(4'h4, d);
        chk("div255", d, 32'hFF);
        mon_clear();
        axi_write(4'h0, 32'h1, 4'hF);
        wait_idle(6000, d);
        chk("f5_status", d, 32'h4);
        chk("f5_csb_lo", 32'(m_csb_lo), 32'd12544);
        chk("f5_sclk_hi", 32'(m_hi), 32'd6144);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
